seq_divider64: RTL



---
 rtl/seq_divider64_if.sv | 49 ++++
 rtl/seq_divider64.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider64_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider64_if
//  Description : Handshake bundle for the sequential divider. The issue side
//                (master) presents operands with in_valid/in_ready and drains
//                results with out_valid/out_ready; the divider is the slave.
//                The is_signed field exists only when DIV_SIGNED_EN is
//                defined.
//  Signals     : in_valid, in_ready, dividend, divisor, [is_signed],
//                out_valid, out_ready, quotient, remainder, div_by_zero
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_divider64_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
`ifdef DIV_SIGNED_EN
    logic             is_signed;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

`ifdef DIV_SIGNED_EN
    modport master (
        output in_valid, dividend, divisor, is_signed, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );
    modport slave (
        input  in_valid, dividend, divisor, is_signed, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
`else
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
`endif
endinterface
`default_nettype wire

// File: rtl/seq_divider64.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider64
//  Description : Multi-cycle radix-2 restoring integer divider. One quotient
//                bit is retired per clock; each trial remainder is formed by
//                a two's-complement subtraction (a + ~b + 1) at WIDTH+1 bits
//                so the borrow out is the restore decision.
//  Ports       : clk  - rising-edge clock
//                rst  - synchronous active-high reset (aborts any operation)
//                bus  - seq_divider64_if.slave
//                       in_valid/in_ready + dividend/divisor[/is_signed] in,
//                       out_valid/out_ready + quotient/remainder/div_by_zero
//  Options     : DIV_SIGNED_EN - adds is_signed and a FIX state that applies
//                the recorded quotient/remainder signs after the unsigned
//                iteration (one extra cycle on every operation).
//  Latency     : WIDTH+1 cycles (WIDTH+2 with DIV_SIGNED_EN), 1 for x/0.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divider64 #(
    parameter int WIDTH = 64
) (
    input  logic            clk,
    input  logic            rst,
    seq_divider64_if.slave  bus
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

`ifdef DIV_SIGNED_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd3
    } state_t;
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             r_state, w_state;
    // Partial remainder. It is always below the divisor between
    // iterations, so WIDTH bits hold it; the WIDTH+1-bit value used by the
    // subtractor is formed from it plus the shifted-in dividend bit.
    logic [WIDTH-1:0]   r_rem,   w_rem;
    // Doubles as the dividend shift register: dividend bits leave at the
    // top while quotient bits enter at the bottom.
    logic [WIDTH-1:0]   r_quo,   w_quo;
    logic [WIDTH-1:0]   r_dvs,   w_dvs;
    logic [c_CNT_W-1:0] r_cnt,   w_cnt;
    logic               r_dbz,   w_dbz;
`ifdef DIV_SIGNED_EN
    logic               r_q_neg, w_q_neg;
    logic               r_r_neg, w_r_neg;
`endif

    // ------------------------------------------------------------------
    // Operand conditioning: magnitudes and result signs
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
`ifdef DIV_SIGNED_EN
    logic             w_a_neg;
    logic             w_b_neg;

    assign w_a_neg = bus.is_signed & bus.dividend[WIDTH-1];
    assign w_b_neg = bus.is_signed & bus.divisor[WIDTH-1];
    // The most-negative value maps onto itself, which read as unsigned is
    // exactly its magnitude, so overflow needs no special case.
    assign w_a_mag = w_a_neg ? ((~bus.dividend) + WIDTH'(1)) : bus.dividend;
    assign w_b_mag = w_b_neg ? ((~bus.divisor)  + WIDTH'(1)) : bus.divisor;
`else
    assign w_a_mag = bus.dividend;
    assign w_b_mag = bus.divisor;
`endif

    // ------------------------------------------------------------------
    // One restoring iteration
    // ------------------------------------------------------------------
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;
    logic           w_last;

    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    // w_shift - {0, divisor}; bit WIDTH set means the subtraction borrowed.
    assign w_trial = w_shift + {1'b1, ~r_dvs} + (WIDTH + 1)'(1);
    assign w_last  = (r_cnt == c_LAST);

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        w_state = r_state;
        w_rem   = r_rem;
        w_quo   = r_quo;
        w_dvs   = r_dvs;
        w_cnt   = r_cnt;
        w_dbz   = r_dbz;
`ifdef DIV_SIGNED_EN
        w_q_neg = r_q_neg;
        w_r_neg = r_r_neg;
`endif
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.divisor == '0) begin
                        // Remainder reports the raw dividend in every mode.
                        w_quo   = '1;
                        w_rem   = bus.dividend;
                        w_dbz   = 1'b1;
`ifdef DIV_SIGNED_EN
                        w_q_neg = 1'b0;
                        w_r_neg = 1'b0;
`endif
                        w_state = ST_DONE;
                    end else begin
                        w_quo   = w_a_mag;
                        w_dvs   = w_b_mag;
                        w_rem   = '0;
                        w_cnt   = '0;
                        w_dbz   = 1'b0;
`ifdef DIV_SIGNED_EN
                        w_q_neg = w_a_neg ^ w_b_neg;
                        w_r_neg = w_a_neg;
`endif
                        w_state = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (!w_trial[WIDTH]) begin
                    w_rem = w_trial[WIDTH-1:0];
                    w_quo = {r_quo[WIDTH-2:0], 1'b1};
                end else begin
                    w_rem = w_shift[WIDTH-1:0];
                    w_quo = {r_quo[WIDTH-2:0], 1'b0};
                end
                w_cnt = r_cnt + c_CNT_W'(1);
                if (w_last) begin
`ifdef DIV_SIGNED_EN
                    w_state = ST_FIX;
`else
                    w_state = ST_DONE;
`endif
                end
            end

`ifdef DIV_SIGNED_EN
            ST_FIX: begin
                if (r_q_neg) begin
                    w_quo = (~r_quo) + WIDTH'(1);
                end
                if (r_r_neg) begin
                    w_rem = (~r_rem) + WIDTH'(1);
                end
                w_state = ST_DONE;
            end
`endif

            ST_DONE: begin
                if (bus.out_ready) begin
                    w_state = ST_IDLE;
                end
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_cnt   <= '0;
            r_dbz   <= 1'b0;
`ifdef DIV_SIGNED_EN
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
`endif
        end else begin
            r_state <= w_state;
            r_rem   <= w_rem;
            r_quo   <= w_quo;
            r_dvs   <= w_dvs;
            r_cnt   <= w_cnt;
            r_dbz   <= w_dbz;
`ifdef DIV_SIGNED_EN
            r_q_neg <= w_q_neg;
            r_r_neg <= w_r_neg;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all decoded from registers)
    // ------------------------------------------------------------------
    assign bus.in_ready    = (r_state == ST_IDLE);
    assign bus.out_valid   = (r_state == ST_DONE);
    assign bus.quotient    = r_quo;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dbz;

endmodule
`default_nettype wire
